riscv64_fetch_unit: RTL

Instruction-fetch front end for the riscv64_soc pipeline. It owns the fetch PC, issues 64-bit aligned requests to instruction memory, and buffers returned beats in a prefetch FIFO. It splits each beat into two 32-bit instructions and presents them, with their PCs, to the IF/ID register through a valid/ready handshake. It honours redirects from branch/jump resolution by flushing buffered and in-flight fetches.

---
 rtl/riscv64_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/riscv64_fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv64_pkg.sv
// Shared types for the riscv64_soc pipeline front end.
package riscv64_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_FLUSH
  } fetch_state_t;

  // One prefetched memory beat; start_hi marks a beat entered at its upper half.
  typedef struct packed {
    logic [XLEN-1:0] beat;
    logic [XLEN-1:0] beat_pc;
    logic            start_hi;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with synchronous flush; DEPTH must be a power of 2.
module fetch_fifo
  import riscv64_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/riscv64_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues aligned 64-bit requests, buffers beats
// and hands 32-bit instructions with their PCs to decode; redirects flush everything.
module riscv64_fetch_unit
  import riscv64_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 64'h0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [OW-1:0]   outstanding, out_nxt;
  logic [OW-1:0]   drop_cnt, drop_nxt;
  logic [CW-1:0]   fifo_count, cnt_nxt;
  logic            req_valid_q, req_valid_d;
  logic            start_arm, lower_done, half_sel;
  logic            req_fire, if_fire, fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head;
  logic            unused_bits;

  assign unused_bits    = ^{redirect_pc[1:0], fetch_pc[2:0]};
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = {fetch_pc[XLEN-1:3], 3'b000};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_BOOT;
    else       state <= state_nxt;
  end

  // FSM next state; redirect overrides everything
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (out_nxt != '0) ? S_FLUSH : S_FETCH;
    end else begin
      unique case (state)
        S_BOOT:  state_nxt = S_FETCH;
        S_FETCH: state_nxt = S_FETCH;
        S_FLUSH: if (drop_cnt == '0) state_nxt = S_FETCH;
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  // Decode-side view of the FIFO head
  always_comb begin
    if_valid = !fifo_empty;
    half_sel = head.start_hi | lower_done;
    if_instr = '0;
    if_pc    = '0;
    if (!fifo_empty) begin
      if_instr = half_sel ? head.beat[63:32] : head.beat[31:0];
      if_pc    = head.beat_pc + XLEN'({half_sel, 2'b00});
    end
  end

  // Credit bookkeeping and next request decision (counts as seen after this edge)
  always_comb begin
    req_fire   = req_valid_q & imem_req_ready;
    if_fire    = if_valid & if_ready;
    out_nxt    = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
    fifo_push  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    fifo_pop   = if_fire && half_sel && !redirect_valid;
    push_entry = '{beat: imem_rsp_data, beat_pc: rsp_pc, start_hi: start_arm};

    drop_nxt = drop_cnt;
    if (redirect_valid)                        drop_nxt = out_nxt;
    else if (imem_rsp_valid && drop_cnt != '0) drop_nxt = drop_cnt - OW'(1);

    cnt_nxt = redirect_valid ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    req_valid_d = !redirect_valid && (state_nxt == S_FETCH) &&
                  (32'(cnt_nxt) + 32'(out_nxt) < FIFO_DEPTH) &&
                  (32'(out_nxt) < MAX_OUTSTANDING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= {RESET_PC[XLEN-1:3], 3'b000};
      outstanding <= '0;
      drop_cnt    <= '0;
      start_arm   <= RESET_PC[2];
      lower_done  <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc;
        rsp_pc     <= {redirect_pc[XLEN-1:3], 3'b000};
        start_arm  <= redirect_pc[2];
        lower_done <= 1'b0;
      end else begin
        if (req_fire) fetch_pc <= {fetch_pc[XLEN-1:3], 3'b000} + XLEN'(8);
        if (fifo_push) begin
          rsp_pc    <= rsp_pc + XLEN'(8);
          start_arm <= 1'b0;
        end
        if (if_fire) lower_done <= !half_sel;
      end
    end
  end

  // The credit rule must make a push into a full FIFO impossible
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full));
  end

endmodule
